// File: rtl/ext_bus_arbiter_pkg.sv
// Shared types for the outbound Arduino bus arbiter.
// Contents: requester indices, arbiter FSM states, the picker decision
// bundle (dec_sig_t), the registered output bundle (ctrl_sig_t) and a
// round-robin successor helper.
package ext_bus_arbiter_pkg;

    localparam int NUM_BUS_REQ = 3;

    typedef enum logic [1:0] {
        REQ_PC  = 2'd0,
        REQ_MDR = 2'd1,
        REQ_MAR = 2'd2
    } req_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_FINISH  = 2'd3
    } arb_state_t;

    // Result of one arbitration round.
    typedef struct packed {
        logic [NUM_BUS_REQ-1:0] gnt;
        req_idx_t               idx;
        logic                   any;
    } dec_sig_t;

    // Everything the arbiter drives to the outside world, held in registers.
    typedef struct packed {
        logic [7:0]             out_bus;
        logic                   out_valid;
        logic [NUM_BUS_REQ-1:0] gnt;
        logic [NUM_BUS_REQ-1:0] done;
        logic                   busy;
        logic                   timeout_err;
    } ctrl_sig_t;

    // Requester that follows i in round-robin order.
    function automatic req_idx_t next_idx(input req_idx_t i);
        case (i)
            REQ_PC:  return REQ_MDR;
            REQ_MDR: return REQ_MAR;
            default: return REQ_PC;
        endcase
    endfunction

endpackage

// File: rtl/ext_bus_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker.
// Ports:
//   req  - request vector, bit i = requester i
//   ptr  - requester with highest priority this round (3 behaves as 0)
//   gnt  - one-hot grant, zero when no request
//   idx  - index of the granted requester
//   any  - at least one request pending
module rr_pick3
    import ext_bus_arbiter_pkg::*;
(
    input  logic [NUM_BUS_REQ-1:0] req,
    input  logic [1:0]             ptr,
    output logic [NUM_BUS_REQ-1:0] gnt,
    output logic [1:0]             idx,
    output logic                   any
);

    // Scan order starting at ptr and wrapping modulo 3.
    logic [1:0] order [NUM_BUS_REQ];

    always_comb begin
        case (ptr)
            2'd1:    order = '{2'd1, 2'd2, 2'd0};
            2'd2:    order = '{2'd2, 2'd0, 2'd1};
            default: order = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    // Walk the scan order backwards so the earliest requester is the last
    // one written and therefore wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        for (int k = NUM_BUS_REQ - 1; k >= 0; k--) begin
            if (req[order[k]]) begin
                gnt           = '0;
                gnt[order[k]] = 1'b1;
                idx           = order[k];
            end
        end
    end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Outbound Arduino bus arbiter: shares one 8-bit host bus between the PC,
// MDR and MAR word sources. A round-robin winner's 16-bit word is latched
// and sent as two bytes, each with a four-phase handshake on
// ard_receive_ready. A stuck handshake is aborted after TIMEOUT cycles.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req[2:0]                    - requests (0=PC, 1=MDR, 2=MAR), level
//   pc_word/mdr_word/mar_word   - candidate words
//   ard_receive_ready           - host byte acknowledge
//   out_bus, out_valid          - byte to host and its qualifier
//   bus_pc/bus_mdr/bus_mar      - one-hot grant to the current owner
//   done[2:0]                   - one-cycle completion pulse per requester
//   busy                        - transfer in progress
//   timeout_err                 - one-cycle pulse on handshake abort
module ext_bus_arbiter
    import ext_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUS_REQ-1:0] req,
    input  logic [15:0]            pc_word,
    input  logic [15:0]            mdr_word,
    input  logic [15:0]            mar_word,
    input  logic                   ard_receive_ready,
    output logic [7:0]             out_bus,
    output logic                   out_valid,
    output logic                   bus_pc,
    output logic                   bus_mdr,
    output logic                   bus_mar,
    output logic [NUM_BUS_REQ-1:0] done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t    state, state_nxt;
    req_idx_t      rr_ptr, rr_ptr_nxt;
    req_idx_t      winner, winner_nxt;
    logic [15:0]   word, word_nxt;
    logic          byte_idx, byte_idx_nxt;
    logic [TW-1:0] timer, timer_nxt;
    ctrl_sig_t     outs, outs_nxt;

    logic [NUM_BUS_REQ-1:0] pick_gnt;
    logic [1:0]             pick_idx;
    logic                   pick_any;
    dec_sig_t               dec;
    logic [15:0]            sel_word;
    logic                   expired;

    function automatic logic [7:0] lead_byte(input logic [15:0] w);
        return MSB_FIRST ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] trail_byte(input logic [15:0] w);
        return MSB_FIRST ? w[7:0] : w[15:8];
    endfunction

    rr_pick3 u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign dec = '{gnt: pick_gnt, idx: req_idx_t'(pick_idx), any: pick_any};

    always_comb begin
        case (dec.idx)
            REQ_MDR: sel_word = mdr_word;
            REQ_MAR: sel_word = mar_word;
            default: sel_word = pc_word;
        endcase
    end

    // A zero TIMEOUT never matches because the compare is gated off.
    assign expired = (TIMEOUT != 0) && (timer == TW'(TIMEOUT));

    // State and all output/datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= REQ_PC;
            winner   <= REQ_PC;
            word     <= '0;
            byte_idx <= 1'b0;
            timer    <= '0;
            outs     <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            winner   <= winner_nxt;
            word     <= word_nxt;
            byte_idx <= byte_idx_nxt;
            timer    <= timer_nxt;
            outs     <= outs_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (dec.any) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (expired)                state_nxt = ST_IDLE;
                else if (ard_receive_ready) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (expired)                 state_nxt = ST_IDLE;
                else if (!ard_receive_ready) state_nxt = byte_idx ? ST_FINISH : ST_SEND;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        outs_nxt             = outs;
        outs_nxt.done        = '0;
        outs_nxt.timeout_err = 1'b0;
        rr_ptr_nxt           = rr_ptr;
        winner_nxt           = winner;
        word_nxt             = word;
        byte_idx_nxt         = byte_idx;

        case (state)
            ST_IDLE: begin
                if (dec.any) begin
                    winner_nxt         = dec.idx;
                    word_nxt           = sel_word;
                    byte_idx_nxt       = 1'b0;
                    outs_nxt.gnt       = dec.gnt;
                    outs_nxt.out_bus   = lead_byte(sel_word);
                    outs_nxt.out_valid = 1'b1;
                    outs_nxt.busy      = 1'b1;
                end
            end
            ST_SEND, ST_RELEASE: begin
                if (expired) begin
                    // Abort: drop the bus and move priority past the stuck owner.
                    outs_nxt.timeout_err = 1'b1;
                    outs_nxt.out_valid   = 1'b0;
                    outs_nxt.out_bus     = '0;
                    outs_nxt.gnt         = '0;
                    outs_nxt.busy        = 1'b0;
                    rr_ptr_nxt           = next_idx(winner);
                end else if (state == ST_SEND) begin
                    if (ard_receive_ready) outs_nxt.out_valid = 1'b0;
                end else if (!ard_receive_ready) begin
                    if (!byte_idx) begin
                        byte_idx_nxt       = 1'b1;
                        outs_nxt.out_bus   = trail_byte(word);
                        outs_nxt.out_valid = 1'b1;
                    end else begin
                        outs_nxt.out_bus = '0;
                    end
                end
            end
            default: begin
                outs_nxt.done[winner] = 1'b1;
                outs_nxt.gnt          = '0;
                outs_nxt.busy         = 1'b0;
                rr_ptr_nxt            = next_idx(winner);
            end
        endcase

        if (state_nxt != state)
            timer_nxt = '0;
        else if (state == ST_SEND || state == ST_RELEASE)
            timer_nxt = timer + TW'(1);
        else
            timer_nxt = '0;
    end

    assign out_bus     = outs.out_bus;
    assign out_valid   = outs.out_valid;
    assign bus_pc      = outs.gnt[REQ_PC];
    assign bus_mdr     = outs.gnt[REQ_MDR];
    assign bus_mar     = outs.gnt[REQ_MAR];
    assign done        = outs.done;
    assign busy        = outs.busy;
    assign timeout_err = outs.timeout_err;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Scoreboard bench for ext_bus_arbiter. Two instances: u_dut (TIMEOUT=8,
// high byte first) and u_dut_l (default TIMEOUT, low byte first).
module tb_ext_bus_arbiter;

    localparam int H_NORMAL = 0;
    localparam int H_NEVER  = 1;
    localparam int H_STUCK  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req, req_l;
    logic [15:0] pc_word, mdr_word, mar_word;
    logic [15:0] pc_word_l, mdr_word_l, mar_word_l;
    logic        ready, ready_l;
    logic [7:0]  out_bus, out_bus_l;
    logic        out_valid, out_valid_l;
    logic        bus_pc, bus_mdr, bus_mar;
    logic        bus_pc_l, bus_mdr_l, bus_mar_l;
    logic [2:0]  done, done_l;
    logic        busy, busy_l;
    logic        timeout_err, timeout_err_l;

    ext_bus_arbiter #(.TIMEOUT(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req(req),
        .pc_word(pc_word), .mdr_word(mdr_word), .mar_word(mar_word),
        .ard_receive_ready(ready),
        .out_bus(out_bus), .out_valid(out_valid),
        .bus_pc(bus_pc), .bus_mdr(bus_mdr), .bus_mar(bus_mar),
        .done(done), .busy(busy), .timeout_err(timeout_err)
    );

    ext_bus_arbiter #(.TIMEOUT(255), .MSB_FIRST(1'b0)) u_dut_l (
        .clk(clk), .rst(rst), .req(req_l),
        .pc_word(pc_word_l), .mdr_word(mdr_word_l), .mar_word(mar_word_l),
        .ard_receive_ready(ready_l),
        .out_bus(out_bus_l), .out_valid(out_valid_l),
        .bus_pc(bus_pc_l), .bus_mdr(bus_mdr_l), .bus_mar(bus_mar_l),
        .done(done_l), .busy(busy_l), .timeout_err(timeout_err_l)
    );

    // Expected bytes: {grant[2:0], byte}. Expected events: {timeout_err, done[2:0]}.
    logic [10:0] byte_q[$];
    logic [10:0] byte_q_l[$];
    logic [3:0]  ev_q[$];
    logic [3:0]  ev_q_l[$];

    int errors = 0;
    int checks = 0;
    int host_mode = H_NORMAL;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, required nothing", name, act);
    endtask

    task automatic host_step(input int mode, input logic ov, input int dly,
                             inout logic rdy, inout int cnt);
        case (mode)
            H_NEVER: rdy = 1'b0;
            H_STUCK: rdy = 1'b1;
            default: begin
                if (rdy) begin
                    if (!ov) rdy = 1'b0;
                end else if (ov) begin
                    if (cnt >= dly - 1) begin
                        rdy = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        endcase
    endtask

    // Host models.
    initial begin : host_a
        int cnt;
        cnt   = 0;
        ready = 1'b0;
        forever begin
            @(negedge clk);
            host_step(host_mode, out_valid, 3, ready, cnt);
        end
    end

    initial begin : host_l
        int cnt;
        cnt     = 0;
        ready_l = 1'b0;
        forever begin
            @(negedge clk);
            host_step(H_NORMAL, out_valid_l, 2, ready_l, cnt);
        end
    end

    // Monitor: pops the scoreboard whenever a DUT presents a new byte or an event.
    logic pv = 1'b0;
    logic pv_l = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !pv) begin
            if (byte_q.size() == 0) unexpected("byte", {bus_mar, bus_mdr, bus_pc, out_bus});
            else check("byte", {bus_mar, bus_mdr, bus_pc, out_bus}, byte_q.pop_front());
        end
        if (done != 3'b000 || timeout_err) begin
            if (ev_q.size() == 0) unexpected("event", {timeout_err, done});
            else check("event", {timeout_err, done}, ev_q.pop_front());
        end
        pv = out_valid;

        if (out_valid_l && !pv_l) begin
            if (byte_q_l.size() == 0) unexpected("byte_l", {bus_mar_l, bus_mdr_l, bus_pc_l, out_bus_l});
            else check("byte_l", {bus_mar_l, bus_mdr_l, bus_pc_l, out_bus_l}, byte_q_l.pop_front());
        end
        if (done_l != 3'b000 || timeout_err_l) begin
            if (ev_q_l.size() == 0) unexpected("event_l", {timeout_err_l, done_l});
            else check("event_l", {timeout_err_l, done_l}, ev_q_l.pop_front());
        end
        pv_l = out_valid_l;
    end

    function automatic logic [2:0] grants(input bit lsb);
        return lsb ? {bus_mar_l, bus_mdr_l, bus_pc_l} : {bus_mar, bus_mdr, bus_pc};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input bit lsb, input string name);
        int n;
        n = 0;
        while (grants(lsb) == 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_grant_seen"}, 32'(grants(lsb) != 3'b000), 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((byte_q.size() + byte_q_l.size() + ev_q.size() + ev_q_l.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, byte_q.size() + byte_q_l.size() + ev_q.size() + ev_q_l.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_out_bus"},     out_bus, 0);
        check({name, "_out_valid"},   out_valid, 0);
        check({name, "_grants"},      grants(1'b0), 0);
        check({name, "_done"},        done, 0);
        check({name, "_busy"},        busy, 0);
        check({name, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int g, n;
        logic pg;
        rst = 1'b1;
        req = '0; pc_word = '0; mdr_word = '0; mar_word = '0;
        req_l = '0; pc_word_l = '0; mdr_word_l = '0; mar_word_l = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check_all_zero("reset");
        check("reset_valid_l", out_valid_l, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single transfer from PC
        pc_word = 16'h1234;
        byte_q.push_back({3'b001, 8'h12});
        byte_q.push_back({3'b001, 8'h34});
        ev_q.push_back({1'b0, 3'b001});
        req = 3'b001;
        wait_grant(1'b0, "single");
        req = 3'b000;
        drain("single");
        check("single_busy_after", busy, 0);
        check("single_grant_after", grants(1'b0), 0);

        // Contention: all three held, expect PC, MDR, MAR, PC
        do_reset();
        pc_word  = 16'h1234;
        mdr_word = 16'hA55A;
        mar_word = 16'h0FF0;
        byte_q.push_back({3'b001, 8'h12}); byte_q.push_back({3'b001, 8'h34}); ev_q.push_back({1'b0, 3'b001});
        byte_q.push_back({3'b010, 8'hA5}); byte_q.push_back({3'b010, 8'h5A}); ev_q.push_back({1'b0, 3'b010});
        byte_q.push_back({3'b100, 8'h0F}); byte_q.push_back({3'b100, 8'hF0}); ev_q.push_back({1'b0, 3'b100});
        byte_q.push_back({3'b001, 8'h12}); byte_q.push_back({3'b001, 8'h34}); ev_q.push_back({1'b0, 3'b001});
        req = 3'b111;
        g = 0; n = 0; pg = 1'b0;
        while (g < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (grants(1'b0) != 3'b000 && !pg) g++;
            pg = (grants(1'b0) != 3'b000);
        end
        check("contention_grants", g, 4);
        req = 3'b000;
        drain("contention");

        // Low byte first, word latched at grant, req dropped mid-transfer
        do_reset();
        mar_word_l = 16'hBEEF;
        byte_q_l.push_back({3'b100, 8'hEF});
        byte_q_l.push_back({3'b100, 8'hBE});
        ev_q_l.push_back({1'b0, 3'b100});
        req_l = 3'b100;
        wait_grant(1'b1, "latch");
        mar_word_l = 16'h0000;
        req_l = 3'b000;
        drain("latch");

        // Timeout on PC, then MDR is served
        do_reset();
        host_mode = H_NEVER;
        pc_word  = 16'hA1B2;
        mdr_word = 16'hC3D4;
        byte_q.push_back({3'b001, 8'hA1});
        ev_q.push_back({1'b1, 3'b000});
        byte_q.push_back({3'b010, 8'hC3});
        byte_q.push_back({3'b010, 8'hD4});
        ev_q.push_back({1'b0, 3'b010});
        req = 3'b011;
        wait_grant(1'b0, "timeout");
        n = 0;
        while (!timeout_err && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 9);
        check("timeout_grants_clear", grants(1'b0), 0);
        check("timeout_valid_clear", out_valid, 0);
        check("timeout_busy_clear", busy, 0);
        host_mode = H_NORMAL;
        @(negedge clk);
        check("timeout_next_grant", grants(1'b0), 3'b010);
        req = 3'b000;
        drain("timeout");

        // Reset after the first byte is acknowledged
        pc_word = 16'hCAFE;
        byte_q.push_back({3'b001, 8'hCA});
        req = 3'b001;
        wait_grant(1'b0, "midrst");
        req = 3'b000;
        n = 0;
        while (out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("midrst_acked", out_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        // From a reset pointer MDR precedes MAR.
        mdr_word = 16'h1357;
        mar_word = 16'h2468;
        byte_q.push_back({3'b010, 8'h13});
        byte_q.push_back({3'b010, 8'h57});
        ev_q.push_back({1'b0, 3'b010});
        req = 3'b110;
        wait_grant(1'b0, "midrst2");
        check("midrst_grant_mdr", grants(1'b0), 3'b010);
        req = 3'b000;
        drain("midrst2");

        // Ready already high when the first byte is presented
        mar_word = 16'h7E81;
        byte_q.push_back({3'b100, 8'h7E});
        byte_q.push_back({3'b100, 8'h81});
        ev_q.push_back({1'b0, 3'b100});
        host_mode = H_STUCK;
        @(negedge clk);
        req = 3'b100;
        wait_grant(1'b0, "early");
        req = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("early_hold_valid", out_valid, 0);
        end
        host_mode = H_NORMAL;
        drain("early");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
